// File: rtl/mas8_pkg.sv
// Shared definitions for the mas8 fetch sequencer: opcode values,
// decoded operation classes and the sequencer state encoding.
package mas8_pkg;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_SRA = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LT  = 4'hC;
  localparam logic [3:0] OP_LTC = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_JMP,
    CLS_LW,
    CLS_SW,
    CLS_NOP
  } op_class_t;

endpackage

// File: rtl/mas8_decode.sv
// Combinational instruction classifier: maps the IR opcode field onto the
// operation class that steers the sequencer.
module mas8_decode
  import mas8_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class
);

  // Unassigned opcodes (1010, 1011, 1110) fall through to NOP.
  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_ADC, OP_ADD, OP_MUL, OP_SRA,
      OP_AND, OP_OR,  OP_NOT, OP_XOR,
      OP_LT,  OP_LTC: op_class = CLS_ALU;
      OP_JMP:         op_class = CLS_JMP;
      OP_LW:          op_class = CLS_LW;
      OP_SW:          op_class = CLS_SW;
      default:        op_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/fetch_seq_8b.sv
// Instruction fetch / data access sequencer for the 8-bit mas8 core:
// fetches into IR, computes load/store addresses and strobes ALU commits.
module fetch_seq_8b
  import mas8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [7:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  input  logic        dmem_ack,
  input  logic [7:0]  dmem_rdata,
  input  logic [7:0]  reg0,
  input  logic [7:0]  reg1,
  input  logic [7:0]  reg2,
  input  logic [7:0]  reg3,
  input  logic [7:0]  radr,
  output logic [3:0]  opcode,
  output logic [1:0]  rd,
  output logic [1:0]  ra,
  output logic [7:0]  c,
  output logic [7:0]  din,
  output logic        en,
  inout  wire         dvdd,
  inout  wire         dgnd
);

  state_t      state, state_next;
  op_class_t   op_class;
  logic [7:0]  pc, pc_next;
  logic [15:0] ir;
  logic [7:0]  ea, wdata_q;
  logic        we_q;
  logic [7:0]  reg_file [4];
  logic        ir_load, mem_latch, din_load;
  logic        en_c, imem_req_c, dmem_req_c;

  assign reg_file = '{reg0, reg1, reg2, reg3};
  assign {opcode, rd, ra, c} = ir;

  mas8_decode u_decode (
    .opcode   (ir[15:12]),
    .op_class (op_class)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      din     <= '0;
      ea      <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (ir_load)
        ir <= imem_rdata;
      if (mem_latch) begin
        ea      <= reg_file[ra] + c;
        wdata_q <= reg_file[rd];
        we_q    <= (op_class == CLS_SW);
      end
      if (din_load)
        din <= dmem_rdata;
    end
  end

  // Acks are only looked at in the state that issued the matching request.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    mem_latch  = 1'b0;
    din_load   = 1'b0;
    en_c       = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_class)
          CLS_ALU: begin
            en_c       = 1'b1;
            pc_next    = pc + 8'd1;
            state_next = ST_FETCH;
          end
          CLS_JMP: begin
            en_c       = 1'b1;
            pc_next    = radr;
            state_next = ST_FETCH;
          end
          CLS_LW, CLS_SW: begin
            mem_latch  = 1'b1;
            state_next = ST_MEM;
          end
          default: begin
            pc_next    = pc + 8'd1;
            state_next = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ack) begin
          if (we_q) begin
            pc_next    = pc + 8'd1;
            state_next = ST_FETCH;
          end else begin
            din_load   = 1'b1;
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        en_c       = 1'b1;
        pc_next    = pc + 8'd1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Strobes are masked while reset is held so an aborted transaction never commits.
  assign imem_req   = imem_req_c & ~rst;
  assign dmem_req   = dmem_req_c & ~rst;
  assign en         = en_c & ~rst;
  assign imem_addr  = pc;
  assign dmem_addr  = ea;
  assign dmem_wdata = wdata_q;
  assign dmem_we    = we_q;

endmodule

// File: doc/fetch_seq_8b.md
FETCH_SEQ_8B -- requirements
Module: fetch_seq_8b

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 SHALL have port clk, input, 1: system clock; one clock domain, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 8: instruction address; equals PC.
REQ-006 SHALL have port imem_ack, input, 1: fetch complete; imem_rdata valid in the same cycle.
REQ-007 SHALL have port imem_rdata, input, 16: instruction word {opcode[15:12], rd[11:10], ra[9:8], c[7:0]}.
REQ-008 SHALL have port dmem_req, output, 1: data memory request.
REQ-009 SHALL have port dmem_we, output, 1: 1 = store, 0 = load.
REQ-010 SHALL have port dmem_addr, output, 8: effective address.
REQ-011 SHALL have port dmem_wdata, output, 8: store data.
REQ-012 SHALL have port dmem_ack, input, 1: data access complete; dmem_rdata valid in the same cycle.
REQ-013 SHALL have port dmem_rdata, input, 8: load data.
REQ-014 SHALL have ports reg0..reg3, input, 8 each: ALU register file values.
REQ-015 SHALL have port radr, input, 8: ALU jump target; valid only while en=1.
REQ-016 SHALL have ports opcode, rd, ra, c, output, 4/2/2/8: fields of the instruction register (IR), driven continuously.
REQ-017 SHALL have port din, output, 8: load data register feeding the ALU.
REQ-018 SHALL have port en, output, 1: ALU commit strobe, asserted for one cycle per committing instruction.
REQ-019 SHALL have ports dvdd and dgnd, inout, 1: digital supply and ground, pass-through.

Function
REQ-020 SHALL implement the states FETCH, EXEC, MEM and WB.
REQ-021 FETCH SHALL hold imem_req=1 with a stable imem_addr until imem_ack, then latch imem_rdata into IR and go to EXEC.
REQ-022 In EXEC, opcodes 0xxx, 01xx, 1100 and 1101 SHALL assert en, set PC <= PC+1 and go to FETCH.
REQ-023 In EXEC, opcode 1111 (jmp) SHALL assert en, set PC <= radr sampled in that cycle and go to FETCH.
REQ-024 In EXEC, opcodes 1000 (lw) and 1001 (sw) SHALL latch ea = reg[ra] + c mod 256 and go to MEM without asserting en.
REQ-025 In EXEC, opcodes 1010, 1011 and 1110 SHALL execute as NOP: en=0, PC <= PC+1.
REQ-026 MEM SHALL hold dmem_req=1 with stable dmem_addr=ea, dmem_we and dmem_wdata=reg[rd] (latched in EXEC) until dmem_ack.
REQ-027 On dmem_ack for lw, MEM SHALL capture dmem_rdata into din and go to WB.
REQ-028 On dmem_ack for sw, MEM SHALL set PC <= PC+1 and go to FETCH; en SHALL NOT be asserted for sw.
REQ-029 WB SHALL assert en with din stable, set PC <= PC+1 and go to FETCH.
REQ-030 PC increment SHALL wrap 8'hFF -> 8'h00; ea addition SHALL wrap modulo 256.
REQ-031 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-032 imem_req and dmem_req SHALL never be asserted in the same cycle.
REQ-033 Throughput SHALL be one instruction per 2 cycles for ALU ops and jmp with zero-wait ack, 3 cycles for sw, and 4 cycles for lw.

Reset
REQ-034 With rst=1 at a clock edge: PC=RESET_PC, IR=16'h0000, din=8'h00, ea=8'h00, state=FETCH.
REQ-035 During and after reset, en, imem_req and dmem_req SHALL be 0 until the next state logic drives them.
REQ-036 Reset mid-transaction SHALL abort the transaction; a pending ack SHALL be ignored and no en SHALL be issued.
REQ-037 imem_req SHALL assert in the first cycle after rst deasserts.

Structure
REQ-038 Shared package mas8_pkg SHALL hold the opcode constants (ADC, ADD, MUL, SRA, AND, OR, NOT, XOR, LW, SW, LT, LTC, JMP) and the state encoding.
REQ-039 Sub-module mas8_decode (combinational: IR -> op class {ALU, JMP, LW, SW, NOP}) SHALL be used; all else SHALL be flat.

Verification
REQ-040 Reset, then imem_rdata=16'h0C05 with zero-wait ack -> imem_addr 0x00 then 0x01, en high exactly one cycle, opcode=0, rd=3, c=0x05.
REQ-041 PC=0xFF, ALU op -> next imem_addr=0x00.
REQ-042 lw with reg1=0x10, c=0x03, dmem_ack after 3 wait cycles, rdata=0xA5 -> dmem_addr=0x13, dmem_we=0, din=0xA5 when en=1, en asserted once.
REQ-043 sw with rd=2, reg2=0x3C, ra=0, reg0=0xFE, c=0x04 -> dmem_addr=0x02, dmem_wdata=0x3C, dmem_we=1, en never high.
REQ-044 jmp with radr=0x40 in EXEC -> next imem_addr=0x40; opcode 1010 -> en=0, PC+1.
REQ-045 rst asserted during MEM with dmem_ack arriving in the next cycle -> no en, PC=RESET_PC, imem_req after rst deasserts.
